// File: rtl/simmem_write_responder.sv
// -----------------------------------------------------------------------------
// simmem_write_responder
//
// Memory-side endpoint of the simulated-memory write path. Accepts write-address
// requests into a small in-order queue, consumes the matching write-data beats
// one burst at a time and returns one write response per burst. The response
// payload carries a status (OKAY/SLVERR) and the received beat count minus one,
// so upstream checkers can predict it exactly.
//
// Ports:
//   clk_i             clock, all state changes on the rising edge
//   rst_ni            asynchronous active-low reset
//   waddr_in_valid_i  write-address valid
//   waddr_in_ready_o  write-address ready (queue not full)
//   waddr_i           write-address request (id, burst_len used)
//   wdata_in_valid_i  write-data valid
//   wdata_in_ready_o  write-data ready (only while a burst is open)
//   wdata_i           write-data beat (last used)
//   wrsp_out_valid_o  write-response valid
//   wrsp_out_ready_i  write-response ready
//   wrsp_o            write response {id, payload}
// -----------------------------------------------------------------------------

package simmem_pkg;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  burst_len;
        logic [2:0]  burst_size;
        logic [1:0]  burst_type;
        logic        lock;
    } waddr_t;  // 48 bits

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } wdata_t;  // 9 bits

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] payload;
    } wrsp_payload_t;

    typedef struct packed {
        wrsp_payload_t merged_payload;
    } wrsp_t;  // 12 bits

    // Only the fields the responder needs are kept in the address queue.
    typedef struct packed {
        logic [1:0] id;
        logic [7:0] burst_len;
    } aw_entry_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

module simmem_write_responder
    import simmem_pkg::*;
#(
    parameter int unsigned AwQueueDepth = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,

    input  logic   waddr_in_valid_i,
    output logic   waddr_in_ready_o,
    input  waddr_t waddr_i,

    input  logic   wdata_in_valid_i,
    output logic   wdata_in_ready_o,
    input  wdata_t wdata_i,

    output logic   wrsp_out_valid_o,
    input  logic   wrsp_out_ready_i,
    output wrsp_t  wrsp_o
);

    localparam int unsigned PtrW = $clog2(AwQueueDepth);

    // -------------------------------------------------------------------------
    // Write-address queue: pointers carry one extra wrap bit so full and empty
    // are distinguishable without a separate occupancy counter.
    // -------------------------------------------------------------------------
    aw_entry_t       aw_mem_q [AwQueueDepth];
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
    logic            aw_full, aw_empty;
    logic            aw_push, aw_pop;
    aw_entry_t       aw_head;
    aw_entry_t       aw_new;

    assign aw_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign aw_empty = (wr_ptr_q == rd_ptr_q);

    // Acceptance looks only at the registered full flag, so a same-cycle pop
    // never lets a full queue take a new request.
    assign waddr_in_ready_o = !aw_full;
    assign aw_push          = waddr_in_valid_i && !aw_full;

    assign aw_new.id        = waddr_i.id;
    assign aw_new.burst_len = waddr_i.burst_len;
    assign aw_head          = aw_mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (aw_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (aw_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: queue storage has no reset; the pointers alone define which entries
    // are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (aw_push) aw_mem_q[wr_ptr_q[PtrW-1:0]] <= aw_new;
    end

    // -------------------------------------------------------------------------
    // Write-data / response FSM with registered handshake outputs.
    // -------------------------------------------------------------------------
    w_state_e   state_q;
    logic [8:0] cnt_q;
    logic       wdata_ready_q;
    logic       wrsp_valid_q;
    wrsp_t      wrsp_q;

    logic       beat_fire;
    logic       len_hit;
    logic       beat_final;
    wrsp_t      wrsp_d;

    assign beat_fire  = wdata_ready_q && wdata_in_valid_i;
    // cnt_q is the number of beats seen before this one.
    assign len_hit    = (cnt_q == {1'b0, aw_head.burst_len});
    assign beat_final = wdata_i.last || len_hit;
    assign aw_pop     = beat_fire && beat_final;

    // OKAY only when the requester's last and the requested length agree.
    assign wrsp_d.merged_payload.id      = aw_head.id;
    assign wrsp_d.merged_payload.payload = {cnt_q[7:0],
                                            (wdata_i.last && len_hit) ? RESP_OKAY : RESP_SLVERR};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= W_IDLE;
            cnt_q         <= '0;
            wdata_ready_q <= 1'b0;
            wrsp_valid_q  <= 1'b0;
            wrsp_q        <= '0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (!aw_empty) begin
                        state_q       <= W_DATA;
                        cnt_q         <= '0;
                        wdata_ready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (beat_fire) begin
                        if (beat_final) begin
                            state_q       <= W_RESP;
                            wdata_ready_q <= 1'b0;
                            wrsp_valid_q  <= 1'b1;
                            wrsp_q        <= wrsp_d;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                    end
                end
                W_RESP: begin
                    // wrsp_q is untouched here, so the response stays stable
                    // for as long as the consumer stalls.
                    if (wrsp_out_ready_i) begin
                        wrsp_valid_q <= 1'b0;
                        if (!aw_empty) begin
                            state_q       <= W_DATA;
                            cnt_q         <= '0;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q <= W_IDLE;
                        end
                    end
                end
                default: begin
                    state_q       <= W_IDLE;
                    wdata_ready_q <= 1'b0;
                    wrsp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wdata_in_ready_o = wdata_ready_q;
    assign wrsp_out_valid_o = wrsp_valid_q;
    assign wrsp_o           = wrsp_q;

    // Request fields that the responder deliberately ignores.
    logic unused_fields;
    assign unused_fields = ^{waddr_i.addr, waddr_i.burst_size, waddr_i.burst_type,
                             waddr_i.lock, wdata_i.data};

endmodule

// File: tb/tb_simmem_write_responder.sv
// -----------------------------------------------------------------------------
// tb_simmem_write_responder
//
// Directed bench for simmem_write_responder. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled at the same point, so every value
// checked is the settled post-edge state. Expected responses are hand computed
// as {id[1:0], beats_minus_1[7:0], status[1:0]}.
// -----------------------------------------------------------------------------

module tb_simmem_write_responder;
    import simmem_pkg::*;

    logic   clk_i = 1'b0;
    logic   rst_ni;
    logic   waddr_in_valid_i;
    logic   waddr_in_ready_o;
    waddr_t waddr_i;
    logic   wdata_in_valid_i;
    logic   wdata_in_ready_o;
    wdata_t wdata_i;
    logic   wrsp_out_valid_o;
    logic   wrsp_out_ready_i;
    wrsp_t  wrsp_o;

    int checks = 0;
    int errors = 0;

    simmem_write_responder #(.AwQueueDepth(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .waddr_in_valid_i (waddr_in_valid_i),
        .waddr_in_ready_o (waddr_in_ready_o),
        .waddr_i          (waddr_i),
        .wdata_in_valid_i (wdata_in_valid_i),
        .wdata_in_ready_o (wdata_in_ready_o),
        .wdata_i          (wdata_i),
        .wrsp_out_valid_o (wrsp_out_valid_o),
        .wrsp_out_ready_i (wrsp_out_ready_i),
        .wrsp_o           (wrsp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one AW and hold it until accepted (bounded).
    task automatic aw_push(input logic [1:0] id, input logic [7:0] len);
        int n;
        waddr_t a;
        a = '0;
        a.id = id;
        a.burst_len = len;
        a.addr = 32'h1000_0000 | {24'd0, len};
        waddr_i = a;
        waddr_in_valid_i = 1'b1;
        n = 0;
        while (!waddr_in_ready_o && n < 50) begin
            step();
            n++;
        end
        check("aw_accept_timeout", {31'd0, waddr_in_ready_o}, 32'd1);
        step();
        waddr_in_valid_i = 1'b0;
    endtask

    // Send n beats; last is set on beat index last_at (-1 = never).
    task automatic send_beats(input int n, input int last_at);
        int w;
        for (int b = 0; b < n; b++) begin
            wdata_i.data = 8'(8'hA0 + b);
            wdata_i.last = (b == last_at);
            wdata_in_valid_i = 1'b1;
            w = 0;
            while (!wdata_in_ready_o && w < 50) begin
                step();
                w++;
            end
            check("w_beat_timeout", {31'd0, wdata_in_ready_o}, 32'd1);
            step();
        end
        wdata_in_valid_i = 1'b0;
        wdata_i.last = 1'b0;
    endtask

    // Response must be valid in the cycle right after the final beat.
    task automatic expect_rsp(input string tag, input logic [11:0] exp);
        check({tag, "_valid"}, {31'd0, wrsp_out_valid_o}, 32'd1);
        check({tag, "_rsp"}, {20'd0, wrsp_o}, {20'd0, exp});
        wrsp_out_ready_i = 1'b1;
        step();
        wrsp_out_ready_i = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, wrsp_out_valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni           = 1'b0;
        waddr_in_valid_i = 1'b0;
        waddr_i          = '0;
        wdata_i          = '0;
        wrsp_out_ready_i = 1'b0;
        // W valid asserted from reset: must be held off until an AW is queued.
        wdata_in_valid_i = 1'b1;

        repeat (2) step();
        check("rst_waddr_ready", {31'd0, waddr_in_ready_o}, 32'd1);
        check("rst_wdata_ready", {31'd0, wdata_in_ready_o}, 32'd0);
        check("rst_wrsp_valid",  {31'd0, wrsp_out_valid_o}, 32'd0);
        check("rst_wrsp",        {20'd0, wrsp_o}, 32'd0);
        rst_ni = 1'b1;

        // --- W before AW, then single OKAY write ---
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_before_aw_ready", {31'd0, wdata_in_ready_o}, 32'd0);
        end
        aw_push(2'd2, 8'd3);
        check("aw_t1_wready", {31'd0, wdata_in_ready_o}, 32'd0);
        step();
        check("aw_t2_wready", {31'd0, wdata_in_ready_o}, 32'd1);
        send_beats(4, 3);
        check("single_wready_resp", {31'd0, wdata_in_ready_o}, 32'd0);
        expect_rsp("single", 12'h80C);
        check("single_idle_wready", {31'd0, wdata_in_ready_o}, 32'd0);

        // --- Early last: SLVERR, 2 beats ---
        aw_push(2'd1, 8'd3);
        send_beats(2, 1);
        expect_rsp("early_last", 12'h406);

        // --- Missing last: burst ends on length, third beat waits ---
        aw_push(2'd0, 8'd1);
        send_beats(2, -1);
        expect_rsp("missing_last", 12'h006);
        wdata_in_valid_i = 1'b1;
        wdata_i.last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("beat3_held", {31'd0, wdata_in_ready_o}, 32'd0);
        end
        // burst_len=0: the waiting beat is final though last=0 -> SLVERR, 1 beat
        aw_push(2'd3, 8'd0);
        send_beats(1, -1);
        expect_rsp("len0_no_last", 12'hC02);

        // --- Queue full plus response backpressure ---
        aw_push(2'd3, 8'd1);
        aw_push(2'd1, 8'd0);
        aw_push(2'd2, 8'd2);
        aw_push(2'd0, 8'd1);
        check("full_waddr_ready", {31'd0, waddr_in_ready_o}, 32'd0);
        send_beats(2, 1);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, wrsp_out_valid_o}, 32'd1);
            check("stall_rsp",   {20'd0, wrsp_o}, 32'h0000_0C04);
            check("stall_wready", {31'd0, wdata_in_ready_o}, 32'd0);
            check("stall_waddr_ready", {31'd0, waddr_in_ready_o}, 32'd1);
            step();
        end
        expect_rsp("drain0", 12'hC04);
        check("drain_gap_wready", {31'd0, wdata_in_ready_o}, 32'd1);
        send_beats(1, 0);
        expect_rsp("drain1", 12'h400);
        send_beats(3, 2);
        expect_rsp("drain2", 12'h808);
        send_beats(2, 1);
        expect_rsp("drain3", 12'h004);

        // --- Asynchronous reset in the middle of a burst ---
        aw_push(2'd1, 8'd3);
        send_beats(2, -1);
        check("pre_rst_wready", {31'd0, wdata_in_ready_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_waddr_ready", {31'd0, waddr_in_ready_o}, 32'd1);
        check("arst_wdata_ready", {31'd0, wdata_in_ready_o}, 32'd0);
        check("arst_wrsp_valid",  {31'd0, wrsp_out_valid_o}, 32'd0);
        check("arst_wrsp",        {20'd0, wrsp_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_wready", {31'd0, wdata_in_ready_o}, 32'd0);
        aw_push(2'd2, 8'd3);
        send_beats(4, 3);
        expect_rsp("post_rst", 12'h80C);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simmem_write_responder.md
# simmem_write_responder

Write-side AXI responder terminating the simulated memory's write channels: it accepts write-address requests (`waddr_t`) and write-data beats (`wdata_t`), and emits one write response (`wrsp_t`) per completed burst. It sits at the downstream (memory) end of the simmem write path, opposite the requester. It provides the memory-side endpoint against which the write response bank and delay calculator are exercised. Response payloads encode status and received beat count so benches can check them deterministically.

## Interface
- `AwQueueDepth`, 4: number of buffered write-address requests; power of two, ≥2.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `waddr_in_valid_i`  in  1  write-address valid.
- `waddr_in_ready_o`  out  1  write-address ready.
- `waddr_i`  in  `$bits(waddr_t)` (48)  write-address request; `id`, `burst_len` used, other fields ignored.
- `wdata_in_valid_i`  in  1  write-data valid.
- `wdata_in_ready_o`  out  1  write-data ready.
- `wdata_i`  in  `$bits(wdata_t)` (9)  write-data beat; only `last` used.
- `wrsp_out_valid_o`  out  1  write-response valid.
- `wrsp_out_ready_i`  in  1  write-response ready.
- `wrsp_o`  out  `$bits(wrsp_t)` (12)  response: `merged_payload.id`, `merged_payload.payload`.

## Operation
- AW queue: FIFO of `{id, burst_len}`, depth `AwQueueDepth`, pointers with an extra wrap bit. Push on `waddr_in_valid_i && waddr_in_ready_o`; `waddr_in_ready_o = !full`. This is independent of a same-cycle pop, so a full queue never accepts.
- W FSM, three states:
  - W_IDLE: `wdata_in_ready_o=0`. Queue non-empty → W_DATA and clear beat counter.
  - W_DATA: `wdata_in_ready_o=1`. Each beat handshake increments the 9-bit beat counter `cnt`.
    - A beat is final if `wdata_i.last==1` or `cnt == burst_len` (counter counted before increment; head `burst_len`).
    - On the final beat, pop the queue head, latch the response, and go to W_RESP.
  - W_RESP: `wrsp_out_valid_o=1`, `wdata_in_ready_o=0`. On `wrsp_out_ready_i`: if the queue is non-empty after the pop → W_DATA with counter cleared; else → W_IDLE.
- Response fields:
  - `id` = head id.
  - `payload[1:0]` = 2'b00 (OKAY) if `last` and `cnt==burst_len` coincide on the final beat, else 2'b10 (SLVERR).
  - `payload[9:2]` = number of beats received minus 1, truncated to 8 bits.
- W beats arriving before any AW are held off (`wdata_in_ready_o=0`); there is no write-data buffering.
- Responses are returned in AW acceptance order; IDs do not reorder.
- `wrsp_o` is held stable while `wrsp_out_valid_o && !wrsp_out_ready_i`.

## Timing
- Reset values:
  - Outputs: `waddr_in_ready_o=1`, `wdata_in_ready_o=0`, `wrsp_out_valid_o=0`, `wrsp_o=0`.
  - State: FSM=W_IDLE, queue empty, `cnt=0`.
- Reset mid-operation: all queued requests, partial bursts and pending responses are discarded immediately and asynchronously.
- AW pushed into an empty queue at cycle t: FSM reaches W_DATA at t+2, because the head becomes visible at t+1.
- Within a burst: one beat per cycle.
- Final beat handshake at cycle t: `wrsp_out_valid_o=1` from t+1.
- Response handshake at t with the queue non-empty: `wdata_in_ready_o=1` at t+1, giving a minimum of 1 idle W cycle between bursts.
- Push and pop in the same cycle: both take effect; occupancy is unchanged.
- `burst_len=0`: the first beat is final regardless of `last`.

## Test plan
- Single write: AW id=2, burst_len=3; 4 beats with `last` on beat 4 → one response, id=2, payload=10'h00C (beats-1=3, OKAY), valid 1 cycle after beat 4.
- Early last: AW id=1, burst_len=3; `last` on beat 2 → response id=1, payload=10'h006 (SLVERR, beats-1=1); next AW then starts a fresh burst.
- Missing last: AW id=0, burst_len=1; beats without `last` → burst ends on beat 2, payload=10'h006; beat 3 waits for the next AW.
- Queue full plus backpressure: push 4 AWs while `wrsp_out_ready_i=0` → `waddr_in_ready_o=0` with 4 entries; W stalls after burst 1. Releasing ready drains 4 responses with ids in push order, and `wrsp_o` stays stable while stalled.
- W before AW: `wdata_in_valid_i=1` from reset → `wdata_in_ready_o=0` until 2 cycles after the AW handshake.
- Async reset asserted mid-burst (2 of 4 beats taken) → all outputs return to reset values in the same cycle; a subsequent AW/W sequence yields a correct OKAY response.
